// File: rtl/a23_trace_pkg.sv
// Shared A23 trace-record definitions: record kinds, header layout and decode helpers.
// Used by the decoder, the tracer-side encoder and the replay bench.
package a23_trace_pkg;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    EXEC   = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    REGCHG = 3'd4
  } trace_kind_e;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    P0   = 2'd1,
    P1   = 2'd2,
    EMIT = 2'd3
  } dec_state_e;

  localparam int KIND_MSB  = 31;
  localparam int KIND_LSB  = 28;
  localparam int REGNO_MSB = 27;
  localparam int REGNO_LSB = 24;
  localparam int RSVD_MSB  = 23;
  localparam int RSVD_LSB  = 4;
  localparam int BE_MSB    = 3;
  localparam int BE_LSB    = 0;

  localparam logic [3:0] REGNO_PC = 4'd15;

  function automatic logic [1:0] num_payload(input trace_kind_e kind);
    logic [1:0] n;
    n = 2'd0;
    case (kind)
      EXEC, MEM_RD, MEM_WR: n = 2'd2;
      REGCHG:               n = 2'd1;
      default:              n = 2'd0;
    endcase
    return n;
  endfunction

  // The tracer only ever reports r0..r14, so r15 in a REGCHG header means corruption.
  function automatic logic is_legal_hdr(input logic [31:0] hdr, input logic r15_is_err);
    logic [3:0] kind;
    logic       legal;
    kind  = hdr[KIND_MSB:KIND_LSB];
    legal = (kind >= 4'd1) && (kind <= 4'd4) && (hdr[RSVD_MSB:RSVD_LSB] == '0);
    if (r15_is_err && (kind == 4'd4) && (hdr[REGNO_MSB:REGNO_LSB] == REGNO_PC))
      legal = 1'b0;
    return legal;
  endfunction

endpackage

// File: rtl/axi4_a23_trace_decoder.sv
// Decodes packed A23 trace records from a 32-bit word stream into one registered
// event per record, counting delivered events and dropped malformed headers.
module axi4_a23_trace_decoder
  import a23_trace_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter bit R15_IS_ERR = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [31:0]          i_tw_data,
  input  logic                 i_tw_valid,
  output logic                 o_tw_ready,
  output logic                 o_ev_valid,
  input  logic                 i_ev_ready,
  output logic [2:0]           o_ev_kind,
  output logic [31:0]          o_ev_addr,
  output logic [31:0]          o_ev_data,
  output logic [3:0]           o_ev_regno,
  output logic [3:0]           o_ev_be,
  output logic [CNT_WIDTH-1:0] o_ev_count,
  output logic [CNT_WIDTH-1:0] o_err_count
);

  dec_state_e           state_q, state_d;
  trace_kind_e          kind_q, kind_d;
  logic [3:0]           regno_q, regno_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic [CNT_WIDTH-1:0] evCount_q, evCount_d;
  logic [CNT_WIDTH-1:0] errCount_q, errCount_d;

  logic        twXfer;
  logic        evXfer;
  trace_kind_e hdrKind;
  logic        hdrLegal;

  assign twXfer   = i_tw_valid && o_tw_ready;
  assign evXfer   = o_ev_valid && i_ev_ready;
  assign hdrKind  = trace_kind_e'(i_tw_data[KIND_LSB+2:KIND_LSB]);
  assign hdrLegal = is_legal_hdr(i_tw_data, R15_IS_ERR);

  // Unused fields are cleared when a header is accepted so a finished event never
  // carries leftovers from the previous record.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    regno_d    = regno_q;
    be_d       = be_q;
    addr_d     = addr_q;
    data_d     = data_q;
    evCount_d  = evCount_q;
    errCount_d = errCount_q;
    case (state_q)
      HDR: begin
        if (twXfer) begin
          if (hdrLegal) begin
            kind_d  = hdrKind;
            regno_d = (hdrKind == REGCHG) ? i_tw_data[REGNO_MSB:REGNO_LSB] : 4'd0;
            be_d    = (hdrKind == MEM_RD || hdrKind == MEM_WR) ?
                      i_tw_data[BE_MSB:BE_LSB] : 4'd0;
            addr_d  = 32'd0;
            data_d  = 32'd0;
            state_d = P0;
          end else begin
            errCount_d = errCount_q + CNT_WIDTH'(1);
          end
        end
      end
      P0: begin
        if (twXfer) begin
          if (num_payload(kind_q) == 2'd1) begin
            data_d  = i_tw_data;
            state_d = EMIT;
          end else begin
            addr_d  = i_tw_data;
            state_d = P1;
          end
        end
      end
      P1: begin
        if (twXfer) begin
          data_d  = i_tw_data;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (evXfer) begin
          evCount_d = evCount_q + CNT_WIDTH'(1);
          state_d   = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= HDR;
      kind_q     <= NONE;
      regno_q    <= 4'd0;
      be_q       <= 4'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      evCount_q  <= '0;
      errCount_q <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      regno_q    <= regno_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      evCount_q  <= evCount_d;
      errCount_q <= errCount_d;
    end
  end

  assign o_tw_ready  = (state_q != EMIT);
  assign o_ev_valid  = (state_q == EMIT);
  assign o_ev_kind   = kind_q;
  assign o_ev_addr   = addr_q;
  assign o_ev_data   = data_q;
  assign o_ev_regno  = regno_q;
  assign o_ev_be     = be_q;
  assign o_ev_count  = evCount_q;
  assign o_err_count = errCount_q;

endmodule

// File: tb/tb_axi4_a23_trace_decoder.sv
// Scoreboard bench for the A23 trace decoder: expected events are queued as records
// are driven and compared when the decoder hands them over.
module tb_axi4_a23_trace_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] twData;
  logic        twValid;
  logic        twReady;
  logic        evValid;
  logic        evReady;
  logic [2:0]  evKind;
  logic [31:0] evAddr;
  logic [31:0] evData;
  logic [3:0]  evRegno;
  logic [3:0]  evBe;
  logic [31:0] evCount;
  logic [31:0] errCount;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  regno;
    logic [3:0]  be;
  } ev_t;

  ev_t expQ[$];
  int  total = 0;
  int  bad = 0;
  int  readyLowCycles = 0;

  always #5 clock = ~clock;

  axi4_a23_trace_decoder #(.CNT_WIDTH(32), .R15_IS_ERR(1'b1)) dut (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_tw_data  (twData),
    .i_tw_valid (twValid),
    .o_tw_ready (twReady),
    .o_ev_valid (evValid),
    .i_ev_ready (evReady),
    .o_ev_kind  (evKind),
    .o_ev_addr  (evAddr),
    .o_ev_data  (evData),
    .o_ev_regno (evRegno),
    .o_ev_be    (evBe),
    .o_ev_count (evCount),
    .o_err_count(errCount)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [2:0] kind, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] regno, input logic [3:0] be);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.regno = regno; e.be = be;
    expQ.push_back(e);
  endtask

  // Called and returning at a falling edge; the word transfers on the rising edge in between.
  task automatic applyStimulus(input logic [31:0] word);
    int n;
    n = 0;
    twData  = word;
    twValid = 1'b1;
    while (!twReady && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) checkOutput("word accept timeout", 64'd0, 64'd1);
    @(negedge clock);
    twValid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (!(expQ.size() == 0 && twReady) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) checkOutput(tag, 64'd0, 64'd1);
  endtask

  // Sampled just after the falling edge, when bench-driven inputs have settled.
  always begin
    @(negedge clock);
    #1;
    if (!reset && evValid && evReady) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected event", 64'd1, 64'd0);
      end else begin
        ev_t e;
        e = expQ.pop_front();
        checkOutput("ev kind",  64'(evKind),  64'(e.kind));
        checkOutput("ev addr",  64'(evAddr),  64'(e.addr));
        checkOutput("ev data",  64'(evData),  64'(e.data));
        checkOutput("ev regno", 64'(evRegno), 64'(e.regno));
        checkOutput("ev be",    64'(evBe),    64'(e.be));
      end
    end
    if (!reset && !twReady) readyLowCycles++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lowBefore;
    reset   = 1'b1;
    twData  = 32'd0;
    twValid = 1'b0;
    evReady = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset ev_valid",  64'(evValid),  64'd0);
    checkOutput("reset tw_ready",  64'(twReady),  64'd1);
    checkOutput("reset ev_count",  64'(evCount),  64'd0);
    checkOutput("reset err_count", 64'(errCount), 64'd0);
    checkOutput("reset fields",    {evAddr, evData}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: single EXEC record
    pushExp(3'd1, 32'h0000_8000, 32'hE3A0_0001, 4'd0, 4'd0);
    applyStimulus(32'h1000_0000);
    applyStimulus(32'h0000_8000);
    applyStimulus(32'hE3A0_0001);
    waitIdle("t1 idle timeout");
    checkOutput("t1 ev_count", 64'(evCount), 64'd1);

    // 2: MEM_WR then REGCHG back-to-back
    lowBefore = readyLowCycles;
    pushExp(3'd3, 32'h0010_0004, 32'hDEAD_BEEF, 4'd0, 4'hF);
    pushExp(3'd4, 32'h0,         32'h0000_0055, 4'd3, 4'h0);
    applyStimulus(32'h3000_000F);
    applyStimulus(32'h0010_0004);
    applyStimulus(32'hDEAD_BEEF);
    applyStimulus(32'h4300_0000);
    applyStimulus(32'h0000_0055);
    waitIdle("t2 idle timeout");
    checkOutput("t2 ready low cycles", 64'(readyLowCycles - lowBefore), 64'd2);
    checkOutput("t2 ev_count", 64'(evCount), 64'd3);

    // 3: consumer stalls for 10 cycles while a word is offered
    evReady = 1'b0;
    pushExp(3'd2, 32'h0000_0040, 32'hCAFE_F00D, 4'd0, 4'hA);
    applyStimulus(32'h2000_000A);
    applyStimulus(32'h0000_0040);
    applyStimulus(32'hCAFE_F00D);
    twData  = 32'h4000_0000;
    twValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("t3 stall ev_valid", 64'(evValid), 64'd1);
      checkOutput("t3 stall tw_ready", 64'(twReady), 64'd0);
      checkOutput("t3 stall addr",     64'(evAddr),  64'h40);
      checkOutput("t3 stall data",     64'(evData),  64'hCAFE_F00D);
      checkOutput("t3 stall be",       64'(evBe),    64'hA);
      checkOutput("t3 stall ev_count", 64'(evCount), 64'd3);
      @(negedge clock);
    end
    twValid = 1'b0;
    evReady = 1'b1;
    @(negedge clock);
    checkOutput("t3 delivered on first ready", 64'(expQ.size()), 64'd0);
    checkOutput("t3 ev_count", 64'(evCount), 64'd4);
    checkOutput("t3 no word consumed", 64'(evValid), 64'd0);

    // 4: malformed headers are dropped, then a legal REGCHG decodes
    applyStimulus(32'h0000_0000);
    applyStimulus(32'h7000_0000);
    applyStimulus(32'h4F00_0000);
    applyStimulus(32'h1001_0000);
    @(negedge clock);
    checkOutput("t4 err_count", 64'(errCount), 64'd4);
    checkOutput("t4 ev_count",  64'(evCount),  64'd4);
    checkOutput("t4 no event",  64'(evValid),  64'd0);
    pushExp(3'd4, 32'h0, 32'h0000_0077, 4'd14, 4'h0);
    applyStimulus(32'h4E00_0000);
    applyStimulus(32'h0000_0077);
    waitIdle("t4 idle timeout");
    checkOutput("t4 ev_count after", 64'(evCount), 64'd5);

    // 5: asynchronous reset in the middle of an EXEC record
    applyStimulus(32'h1000_0000);
    applyStimulus(32'h0000_1234);
    #2 reset = 1'b1;
    #1;
    checkOutput("t5 reset tw_ready",  64'(twReady),  64'd1);
    checkOutput("t5 reset ev_valid",  64'(evValid),  64'd0);
    checkOutput("t5 reset ev_count",  64'(evCount),  64'd0);
    checkOutput("t5 reset err_count", 64'(errCount), 64'd0);
    checkOutput("t5 reset addr/data", {evAddr, evData}, 64'd0);
    checkOutput("t5 reset kind",      64'(evKind),   64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    pushExp(3'd2, 32'h0000_0020, 32'h0000_1234, 4'd0, 4'h3);
    applyStimulus(32'h2000_0003);
    applyStimulus(32'h0000_0020);
    applyStimulus(32'h0000_1234);
    waitIdle("t5 idle timeout");
    checkOutput("t5 ev_count",  64'(evCount),  64'd1);
    checkOutput("t5 err_count", 64'(errCount), 64'd0);

    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
